// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter.
// Holds width defaults, FSM encoding and the tie-break helper.
package mem_bus_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF    = 27;
    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned TIMEOUT_DEF   = 4096;
    localparam logic [31:0] TIMEOUT_Q_DEF = 32'hDEAD_BEEF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_t;

    // Called only when at least one slot is pending.
    function automatic logic pick_grant(input logic p0, input logic p1,
                                        input logic fixed_prio, input logic last_grant);
        if (p0 && p1) begin
            return fixed_prio ? 1'b0 : ~last_grant;
        end
        return p1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_req_slot.sv
// One master's request slot: latches a start pulse and holds it until the
// arbiter completes it; flags a start that arrives while already pending.
module mem_bus_arbiter_req_slot
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_we,
    input  logic              i_clear,
    output logic              o_pending,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_we,
    output logic              o_proto_err
);

    logic              r_pending;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_we;
    logic              w_capture;

    // A start on the completion edge of this slot is a legal recapture.
    assign w_capture   = i_start && (!r_pending || i_clear);
    assign o_proto_err = i_start && r_pending && !i_clear;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pending <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_we      <= 1'b0;
        end else if (w_capture) begin
            r_pending <= 1'b1;
            r_addr    <= i_addr;
            r_data    <= i_data;
            r_we      <= i_we;
        end else if (i_clear) begin
            r_pending <= 1'b0;
        end
    end

    assign o_pending = r_pending;
    assign o_addr    = r_addr;
    assign o_data    = r_data;
    assign o_we      = r_we;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one MemoryUnit bus between CPU (m0) and DMA (m1): one transaction at
// a time, round-robin or fixed-priority grant, watchdog on a lost bus_done.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned       ADDR_W     = ADDR_W_DEF,
    parameter int unsigned       DATA_W     = DATA_W_DEF,
    parameter int unsigned       FIXED_PRIO = 0,
    parameter int unsigned       TIMEOUT    = TIMEOUT_DEF,
    parameter logic [DATA_W-1:0] TIMEOUT_Q  = DATA_W'(TIMEOUT_Q_DEF)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_data,
    input  logic              i_m0_we,
    input  logic              i_m0_start,
    output logic [DATA_W-1:0] o_m0_q,
    output logic              o_m0_done,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_data,
    input  logic              i_m1_we,
    input  logic              i_m1_start,
    output logic [DATA_W-1:0] o_m1_q,
    output logic              o_m1_done,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_data,
    output logic              o_bus_we,
    output logic              o_bus_start,
    input  logic [DATA_W-1:0] i_bus_q,
    input  logic              i_bus_done,
    output logic              o_owner,
    output logic              o_busy,
    input  logic              i_err_clear,
    output logic              o_err_timeout,
    output logic              o_err_proto
);

    localparam int unsigned       WDOG_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t        r_state;
    logic              r_owner;
    logic              r_busy;
    logic              r_last_grant;
    logic [WDOG_W-1:0] r_wdog;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_data;
    logic              r_bus_we;
    logic              r_bus_start;
    logic [DATA_W-1:0] r_m0_q;
    logic [DATA_W-1:0] r_m1_q;
    logic              r_m0_done;
    logic              r_m1_done;
    logic              r_err_timeout;
    logic              r_err_proto;

    logic              w_p0, w_p1, w_we0, w_we1, w_perr0, w_perr1;
    logic [ADDR_W-1:0] w_addr0, w_addr1;
    logic [DATA_W-1:0] w_data0, w_data1;
    logic              w_grant, w_tmo, w_complete, w_tmo_fire, w_proto;
    logic              w_clr0, w_clr1;
    logic [DATA_W-1:0] w_rsp_q;

    mem_bus_arbiter_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
        .i_clk       (i_clk),
        .i_rst       (i_reset),
        .i_start     (i_m0_start),
        .i_addr      (i_m0_addr),
        .i_data      (i_m0_data),
        .i_we        (i_m0_we),
        .i_clear     (w_clr0),
        .o_pending   (w_p0),
        .o_addr      (w_addr0),
        .o_data      (w_data0),
        .o_we        (w_we0),
        .o_proto_err (w_perr0)
    );

    mem_bus_arbiter_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
        .i_clk       (i_clk),
        .i_rst       (i_reset),
        .i_start     (i_m1_start),
        .i_addr      (i_m1_addr),
        .i_data      (i_m1_data),
        .i_we        (i_m1_we),
        .i_clear     (w_clr1),
        .o_pending   (w_p1),
        .o_addr      (w_addr1),
        .o_data      (w_data1),
        .o_we        (w_we1),
        .o_proto_err (w_perr1)
    );

    assign w_grant    = pick_grant(w_p0, w_p1, FIXED_PRIO != 0, r_last_grant);
    assign w_tmo      = (TIMEOUT != 0) && (r_wdog == WDOG_LAST);
    assign w_complete = (r_state == ST_WAIT) && (i_bus_done || w_tmo);
    assign w_tmo_fire = (r_state == ST_WAIT) && !i_bus_done && w_tmo;
    assign w_clr0     = w_complete && !r_owner;
    assign w_clr1     = w_complete && r_owner;
    // A real bus_done wins over a watchdog expiry landing on the same cycle.
    assign w_rsp_q    = i_bus_done ? i_bus_q : TIMEOUT_Q;
    assign w_proto    = w_perr0 || w_perr1 || ((r_state == ST_IDLE) && i_bus_done);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_owner       <= 1'b0;
            r_busy        <= 1'b0;
            r_last_grant  <= 1'b1;
            r_wdog        <= '0;
            r_bus_addr    <= '0;
            r_bus_data    <= '0;
            r_bus_we      <= 1'b0;
            r_bus_start   <= 1'b0;
            r_m0_q        <= '0;
            r_m1_q        <= '0;
            r_m0_done     <= 1'b0;
            r_m1_done     <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_proto   <= 1'b0;
        end else begin
            r_m0_done <= 1'b0;
            r_m1_done <= 1'b0;

            // Set events take precedence over a simultaneous clear.
            if (w_proto) begin
                r_err_proto <= 1'b1;
            end else if (i_err_clear) begin
                r_err_proto <= 1'b0;
            end
            if (w_tmo_fire) begin
                r_err_timeout <= 1'b1;
            end else if (i_err_clear) begin
                r_err_timeout <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_p0 || w_p1) begin
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_busy       <= 1'b1;
                        r_bus_start  <= 1'b1;
                        r_bus_addr   <= w_grant ? w_addr1 : w_addr0;
                        r_bus_data   <= w_grant ? w_data1 : w_data0;
                        r_bus_we     <= w_grant ? w_we1 : w_we0;
                        r_wdog       <= '0;
                        r_state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_bus_start <= 1'b0;
                    r_wdog      <= r_wdog + WDOG_W'(1);
                    if (w_complete) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                        if (r_owner) begin
                            r_m1_q    <= w_rsp_q;
                            r_m1_done <= 1'b1;
                        end else begin
                            r_m0_q    <= w_rsp_q;
                            r_m0_done <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_m0_q        = r_m0_q;
    assign o_m0_done     = r_m0_done;
    assign o_m1_q        = r_m1_q;
    assign o_m1_done     = r_m1_done;
    assign o_bus_addr    = r_bus_addr;
    assign o_bus_data    = r_bus_data;
    assign o_bus_we      = r_bus_we;
    assign o_bus_start   = r_bus_start;
    assign o_owner       = r_owner;
    assign o_busy        = r_busy;
    assign o_err_timeout = r_err_timeout;
    assign o_err_proto   = r_err_proto;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios on a round-robin instance plus
// random traffic on round-robin and fixed-priority instances against a model.
module tb_mem_bus_arbiter;

    localparam int AW  = 27;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // index [k][x]: k = instance (0 round-robin, 1 fixed priority), x = master
    logic [AW-1:0] m_addr  [2][2];
    logic [DW-1:0] m_data  [2][2];
    logic          m_we    [2][2];
    logic          m_start [2][2];
    logic [DW-1:0] m_q     [2][2];
    logic          m_done  [2][2];
    logic [AW-1:0] bus_addr  [2];
    logic [DW-1:0] bus_data  [2];
    logic          bus_we    [2];
    logic          bus_start [2];
    logic [DW-1:0] bus_q     [2];
    logic          bus_done  [2];
    logic          owner     [2];
    logic          busy      [2];
    logic          err_clear   [2];
    logic          err_timeout [2];
    logic          err_proto   [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        mem_bus_arbiter #(
            .ADDR_W     (AW),
            .DATA_W     (DW),
            .FIXED_PRIO (k),
            .TIMEOUT    (TMO),
            .TIMEOUT_Q  (32'hDEADBEEF)
        ) u_dut (
            .i_clk         (clk),
            .i_reset       (rst),
            .i_m0_addr     (m_addr[k][0]),
            .i_m0_data     (m_data[k][0]),
            .i_m0_we       (m_we[k][0]),
            .i_m0_start    (m_start[k][0]),
            .o_m0_q        (m_q[k][0]),
            .o_m0_done     (m_done[k][0]),
            .i_m1_addr     (m_addr[k][1]),
            .i_m1_data     (m_data[k][1]),
            .i_m1_we       (m_we[k][1]),
            .i_m1_start    (m_start[k][1]),
            .o_m1_q        (m_q[k][1]),
            .o_m1_done     (m_done[k][1]),
            .o_bus_addr    (bus_addr[k]),
            .o_bus_data    (bus_data[k]),
            .o_bus_we      (bus_we[k]),
            .o_bus_start   (bus_start[k]),
            .i_bus_q       (bus_q[k]),
            .i_bus_done    (bus_done[k]),
            .o_owner       (owner[k]),
            .o_busy        (busy[k]),
            .i_err_clear   (err_clear[k]),
            .o_err_timeout (err_timeout[k]),
            .o_err_proto   (err_proto[k])
        );
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference model: one outstanding request per master, grant rule from the
    // pending set at decision time, memory answers with a fixed function.
    bit            model_on  [2];
    bit            drive_on  [2];
    int            start_div [2];
    bit            out_pend  [2][2];
    logic [AW-1:0] req_addr  [2][2];
    logic [DW-1:0] req_data  [2][2];
    bit            req_we    [2][2];
    int            req_cyc   [2][2];
    int            grants    [2][2];
    bit            last_g    [2];
    bit            in_flight [2];
    bit            fl_owner  [2];
    bit            resp_act  [2];
    int            resp_cnt  [2];
    logic [DW-1:0] resp_q    [2];
    int            done_cyc  [2];

    function automatic logic [DW-1:0] mem_q(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we);
        return we ? ~d : ({a, 5'b0} ^ 32'h5A5A_C3C3);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            last_g[k] = 1'b1;
            in_flight[k] = 1'b0;
            resp_act[k] = 1'b0;
            for (int x = 0; x < 2; x++) begin
                out_pend[k][x] = 1'b0;
                grants[k][x] = 0;
            end
        end
    endtask

    task automatic respond(input int k);
        bus_done[k] = 1'b0;
        bus_q[k] = $urandom;
        if (resp_act[k]) begin
            if (resp_cnt[k] == 0) begin
                bus_done[k] = 1'b1;
                bus_q[k] = resp_q[k];
                resp_act[k] = 1'b0;
                done_cyc[k] = cyc;
            end else begin
                resp_cnt[k]--;
            end
        end
    endtask

    task automatic monitor(input int k);
        logic [1:0] p;
        logic       e;
        for (int x = 0; x < 2; x++) begin
            if (m_done[k][x]) begin
                chk("done_owner", {in_flight[k], fl_owner[k]}, {1'b1, x[0]});
                chk("done_latency", cyc, done_cyc[k] + 1);
                chk("done_q", m_q[k][x], mem_q(req_addr[k][x], req_data[k][x], req_we[k][x]));
                out_pend[k][x] = 1'b0;
                in_flight[k] = 1'b0;
            end
        end
        if (bus_start[k]) begin
            chk("start_while_busy", in_flight[k], 1'b0);
            for (int x = 0; x < 2; x++)
                p[x] = out_pend[k][x] && (req_cyc[k][x] <= cyc - 2);
            // instance 1 is the fixed-priority one
            e = (p == 2'b11) ? ((k == 1) ? 1'b0 : ~last_g[k]) : p[1];
            chk("grant_any", p != 2'b00, 1'b1);
            chk("grant_owner", owner[k], e);
            chk("grant_addr", bus_addr[k], req_addr[k][e]);
            chk("grant_data", bus_data[k], req_data[k][e]);
            chk("grant_we", bus_we[k], req_we[k][e]);
            chk("grant_busy", busy[k], 1'b1);
            last_g[k] = e;
            grants[k][e]++;
            in_flight[k] = 1'b1;
            fl_owner[k] = e;
            resp_act[k] = 1'b1;
            resp_cnt[k] = $urandom_range(0, 5);
            resp_q[k] = mem_q(bus_addr[k], bus_data[k], bus_we[k]);
        end
        chk("rand_err_proto", err_proto[k], 1'b0);
        chk("rand_err_timeout", err_timeout[k], 1'b0);
    endtask

    task automatic drive(input int k);
        for (int x = 0; x < 2; x++) begin
            m_start[k][x] = 1'b0;
            if (drive_on[k] && !out_pend[k][x] && $urandom_range(0, start_div[k] - 1) == 0) begin
                req_addr[k][x] = AW'($urandom);
                req_data[k][x] = $urandom;
                req_we[k][x]   = 1'($urandom_range(0, 1));
                req_cyc[k][x]  = cyc;
                out_pend[k][x] = 1'b1;
                m_addr[k][x]   = req_addr[k][x];
                m_data[k][x]   = req_data[k][x];
                m_we[k][x]     = req_we[k][x];
                m_start[k][x]  = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (model_on[k]) begin
                respond(k);
                monitor(k);
                drive(k);
            end
        end
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < 2; k++) begin
            for (int x = 0; x < 2; x++) begin
                m_addr[k][x] = '0;
                m_data[k][x] = '0;
                m_we[k][x] = 1'b0;
                m_start[k][x] = 1'b0;
            end
            bus_q[k] = '0;
            bus_done[k] = 1'b0;
            err_clear[k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic req(input int x, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we);
        m_addr[0][x] = a;
        m_data[0][x] = d;
        m_we[0][x] = we;
        m_start[0][x] = 1'b1;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!bus_start[0] && n < 40) begin
            step();
            n++;
        end
        chk("bus_start_seen", bus_start[0], 1'b1);
    endtask

    // Called in the bus_start cycle; returns in the cycle m_done is visible.
    task automatic finish(input logic [DW-1:0] q);
        step();
        bus_done[0] = 1'b1;
        bus_q[0] = q;
        step();
        bus_done[0] = 1'b0;
    endtask

    task automatic clear_errs();
        err_clear[0] = 1'b1;
        step();
        err_clear[0] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            model_on[k] = 1'b0;
            drive_on[k] = 1'b0;
            start_div[k] = 1;
        end
        rst = 1'b1;
        idle_inputs();
        #5;
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy", busy[k], 1'b0);
            chk("rst_bus_start", bus_start[k], 1'b0);
            chk("rst_done", {m_done[k][0], m_done[k][1]}, 2'b00);
            chk("rst_errs", {err_timeout[k], err_proto[k]}, 2'b00);
        end
        do_reset();

        // single read, latency and routing
        req(0, 27'h000100, 32'h0, 1'b0);
        step();
        m_start[0][0] = 1'b0;
        chk("t1_no_start_t1", bus_start[0], 1'b0);
        step();
        chk("t1_start_t2", bus_start[0], 1'b1);
        chk("t1_addr", bus_addr[0], 27'h000100);
        chk("t1_owner_busy", {owner[0], busy[0]}, 2'b01);
        step();
        chk("t1_start_pulse", bus_start[0], 1'b0);
        repeat (3) step();
        chk("t1_addr_hold", bus_addr[0], 27'h000100);
        step();
        bus_done[0] = 1'b1;
        bus_q[0] = 32'h12345678;
        step();
        bus_done[0] = 1'b0;
        chk("t1_m0_done", m_done[0][0], 1'b1);
        chk("t1_m0_q", m_q[0][0], 32'h12345678);
        chk("t1_m1_done", m_done[0][1], 1'b0);
        chk("t1_idle", busy[0], 1'b0);
        step();
        chk("t1_done_pulse", m_done[0][0], 1'b0);

        // round-robin ties after reset
        do_reset();
        req(0, 27'h200, 32'h0, 1'b0);
        req(1, 27'h300, 32'h0, 1'b0);
        step();
        m_start[0][0] = 1'b0;
        m_start[0][1] = 1'b0;
        wait_start();
        chk("t2_first_m0", {owner[0], bus_addr[0]}, {1'b0, 27'h200});
        finish(32'h1);
        wait_start();
        chk("t2_then_m1", {owner[0], bus_addr[0]}, {1'b1, 27'h300});
        finish(32'h2);
        chk("t2_m1_done", {m_done[0][1], m_q[0][1]}, {1'b1, 32'h2});
        req(0, 27'h400, 32'h0, 1'b0);
        req(1, 27'h500, 32'h0, 1'b0);
        step();
        m_start[0][0] = 1'b0;
        m_start[0][1] = 1'b0;
        wait_start();
        chk("t2_third_tie_m0", {owner[0], bus_addr[0]}, {1'b0, 27'h400});
        finish(32'h3);
        wait_start();
        finish(32'h4);

        // watchdog
        do_reset();
        req(0, 27'h10, 32'h0, 1'b0);
        step();
        m_start[0][0] = 1'b0;
        step();
        chk("t4_start", bus_start[0], 1'b1);
        repeat (15) step();
        chk("t4_not_yet", {m_done[0][0], err_timeout[0]}, 2'b00);
        step();
        chk("t4_done", m_done[0][0], 1'b1);
        chk("t4_q", m_q[0][0], 32'hDEADBEEF);
        chk("t4_err_timeout", err_timeout[0], 1'b1);
        chk("t4_idle", busy[0], 1'b0);
        step();
        err_clear[0] = 1'b1;
        chk("t4_sticky", err_timeout[0], 1'b1);
        step();
        err_clear[0] = 1'b0;
        chk("t4_cleared", err_timeout[0], 1'b0);
        bus_done[0] = 1'b1;
        step();
        bus_done[0] = 1'b0;
        chk("t4_late_done_proto", err_proto[0], 1'b1);
        chk("t4_late_no_done", {m_done[0][0], m_done[0][1]}, 2'b00);

        // start while pending, stray done, set-beats-clear
        clear_errs();
        chk("t5_clean", err_proto[0], 1'b0);
        req(0, 27'h0AAA, 32'h0, 1'b0);
        step();
        m_start[0][0] = 1'b0;
        req(1, 27'h1111, 32'hCAFE0001, 1'b1);
        step();
        req(1, 27'h2222, 32'h0BAD0BAD, 1'b0);
        chk("t5_m0_granted", {bus_start[0], owner[0]}, 2'b10);
        step();
        m_start[0][1] = 1'b0;
        chk("t5_err_proto", err_proto[0], 1'b1);
        chk("t5_no_m1_done", m_done[0][1], 1'b0);
        finish(32'h55);
        chk("t5_m0_done", {m_done[0][0], m_done[0][1]}, 2'b10);
        wait_start();
        chk("t5_slot_kept", {owner[0], bus_addr[0], bus_data[0], bus_we[0]},
            {1'b1, 27'h1111, 32'hCAFE0001, 1'b1});
        finish(32'h77);
        chk("t5_m1_q", {m_done[0][1], m_q[0][1]}, {1'b1, 32'h77});
        step();
        clear_errs();
        chk("t5_cleared", err_proto[0], 1'b0);
        bus_done[0] = 1'b1;
        err_clear[0] = 1'b1;
        step();
        bus_done[0] = 1'b0;
        err_clear[0] = 1'b0;
        chk("t5_stray_set_wins", err_proto[0], 1'b1);
        chk("t5_stray_no_done", {m_done[0][0], m_done[0][1], busy[0]}, 3'b000);

        // restart on own completion edge
        clear_errs();
        req(0, 27'h0C0C, 32'h0, 1'b0);
        step();
        m_start[0][0] = 1'b0;
        wait_start();
        step();
        bus_done[0] = 1'b1;
        bus_q[0] = 32'h5;
        req(0, 27'h0D0D, 32'h0, 1'b0);
        step();
        bus_done[0] = 1'b0;
        m_start[0][0] = 1'b0;
        chk("t7_done", m_done[0][0], 1'b1);
        chk("t7_no_proto", err_proto[0], 1'b0);
        wait_start();
        chk("t7_recaptured", {owner[0], bus_addr[0]}, {1'b0, 27'h0D0D});
        finish(32'h6);

        // reset in WAIT
        step();
        req(1, 27'h0E0E, 32'h0, 1'b0);
        step();
        m_start[0][1] = 1'b0;
        wait_start();
        step();
        #3 rst = 1'b1;
        #1;
        chk("t6_async_clear", {busy[0], owner[0], bus_start[0], bus_addr[0]}, '0);
        step();
        step();
        rst = 1'b0;
        repeat (3) begin
            step();
            chk("t6_no_done", {m_done[0][0], m_done[0][1], busy[0]}, 3'b000);
        end
        req(1, 27'h0F0F, 32'h0, 1'b1);
        step();
        m_start[0][1] = 1'b0;
        step();
        chk("t6_restart", {bus_start[0], owner[0], bus_addr[0]}, {2'b11, 27'h0F0F});
        finish(32'h9);
        chk("t6_m1_done", {m_done[0][1], m_q[0][1]}, {1'b1, 32'h9});

        // random traffic on both instances
        do_reset();
        start_div[0] = 4;
        start_div[1] = 1;
        for (int k = 0; k < 2; k++) begin
            model_on[k] = 1'b1;
            drive_on[k] = 1'b1;
        end
        repeat (3000) step();
        drive_on[0] = 1'b0;
        drive_on[1] = 1'b0;
        repeat (40) step();
        for (int k = 0; k < 2; k++) begin
            for (int x = 0; x < 2; x++) begin
                chk("drained", out_pend[k][x], 1'b0);
                chk("served", grants[k][x] > 0, 1'b1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
